// File: rtl/rf_pkg.sv
// Shared types and constants for the regfile_sb register file.
// Holds the write-mode encoding, the default geometry and the helper that
// turns a write mode into a per-bit lane mask.
package rf_pkg;

    localparam int RF_DATA_W     = 16;
    localparam int RF_NUM_REGS   = 16;
    localparam int RF_MAX_DATA_W = 256;

    typedef enum logic [1:0] {
        WM_FULL = 2'b00,
        WM_LO   = 2'b01,
        WM_HI   = 2'b10,
        WM_RSVD = 2'b11
    } wmode_t;

    // Returns a mask with a 1 for every bit of a dataW-wide word that the
    // given mode writes; callers truncate the result to their own width.
    function automatic logic [RF_MAX_DATA_W-1:0] laneMask(input wmode_t mode, input int dataW);
        logic [RF_MAX_DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < RF_MAX_DATA_W; b++) begin
            if (b < dataW) begin
                case (mode)
                    WM_FULL: m[b] = 1'b1;
                    WM_LO:   m[b] = (b < dataW / 2);
                    WM_HI:   m[b] = (b >= dataW / 2);
                    default: m[b] = 1'b0;
                endcase
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between the pipeline (decode issue/read, writeback write/clear) and
// the regfile_sb register file with its busy scoreboard.
interface regfile_sb_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
);

    logic [ADDR_W-1:0]   SrcReg1;
    logic [ADDR_W-1:0]   SrcReg2;
    logic [DATA_W-1:0]   SrcData1;
    logic [DATA_W-1:0]   SrcData2;
    logic [ADDR_W-1:0]   DstReg;
    logic                WriteReg;
    logic [1:0]          WMode;
    logic [DATA_W-1:0]   DstData;
    logic                IssueVld;
    logic [ADDR_W-1:0]   IssueReg;
    logic                Busy1;
    logic                Busy2;
    logic [NUM_REGS-1:0] BusyVec;

    modport master (
        output SrcReg1, SrcReg2, DstReg, WriteReg, WMode, DstData, IssueVld, IssueReg,
        input  SrcData1, SrcData2, Busy1, Busy2, BusyVec
    );

    modport slave (
        input  SrcReg1, SrcReg2, DstReg, WriteReg, WMode, DstData, IssueVld, IssueReg,
        output SrcData1, SrcData2, Busy1, Busy2, BusyVec
    );

endinterface

// File: rtl/rf_word.sv
// One register-file word with a per-bit write mask, so half-lane writes
// leave the untouched lanes holding their old contents.
module rf_word #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] mask,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q
);

    // Clear on reset, otherwise merge masked new bits over the held value
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= (q & ~mask) | (din & mask);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file: two combinational read ports, one masked
// write port (full / low half / high half) and a per-register busy
// scoreboard for RAW hazard detection.
// Optional macro RF_BYPASS_EN: write-through forwarding on the read ports
// and write-clear lookahead on the Busy outputs.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);

    logic [DATA_W-1:0]   regQ [NUM_REGS];
    logic [DATA_W-1:0]   wMask;
    logic [NUM_REGS-1:0] busyQ;
    logic [NUM_REGS-1:0] busyNext;
    logic [DATA_W-1:0]   rdData1;
    logic [DATA_W-1:0]   rdData2;
    logic                rdBusy1;
    logic                rdBusy2;

    // Lane mask for the current write; the reserved mode yields an empty mask
    always_comb begin
        wMask = DATA_W'(laneMask(wmode_t'(bus.WMode), DATA_W));
    end

    // Storage words; the zero register is a constant and gets no flops
    for (genvar i = 0; i < NUM_REGS; i++) begin : gReg
        if (ZERO_REG != 0 && i == 0) begin : gZero
            assign regQ[i] = '0;
        end else begin : gWord
            logic wordWe;
            assign wordWe = bus.WriteReg && (bus.DstReg == ADDR_W'(i));
            rf_word #(.DATA_W(DATA_W)) uWord (
                .clk  (clk),
                .rst  (rst),
                .we   (wordWe),
                .mask (wMask),
                .din  (bus.DstData),
                .q    (regQ[i])
            );
        end
    end

`ifdef RF_BYPASS_EN
    logic srcHit1;
    logic srcHit2;

    // A same-cycle write to a read index forwards its merged value and hides the busy bit it clears
    always_comb begin
        srcHit1 = bus.WriteReg && (bus.DstReg == bus.SrcReg1)
                  && !(ZERO_REG != 0 && bus.SrcReg1 == '0);
        srcHit2 = bus.WriteReg && (bus.DstReg == bus.SrcReg2)
                  && !(ZERO_REG != 0 && bus.SrcReg2 == '0);
        rdData1 = regQ[bus.SrcReg1];
        rdData2 = regQ[bus.SrcReg2];
        rdBusy1 = busyQ[bus.SrcReg1];
        rdBusy2 = busyQ[bus.SrcReg2];
        if (srcHit1) begin
            rdData1 = (rdData1 & ~wMask) | (bus.DstData & wMask);
            rdBusy1 = 1'b0;
        end
        if (srcHit2) begin
            rdData2 = (rdData2 & ~wMask) | (bus.DstData & wMask);
            rdBusy2 = 1'b0;
        end
    end
`else
    // Reads return the stored word and the registered busy bit only
    always_comb begin
        rdData1 = regQ[bus.SrcReg1];
        rdData2 = regQ[bus.SrcReg2];
        rdBusy1 = busyQ[bus.SrcReg1];
        rdBusy2 = busyQ[bus.SrcReg2];
    end
`endif

    // Next busy bitmap: writeback clears first so a same-cycle issue to that index still wins
    always_comb begin
        busyNext = busyQ;
        if (bus.WriteReg) begin
            busyNext[bus.DstReg] = 1'b0;
        end
        if (bus.IssueVld) begin
            busyNext[bus.IssueReg] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busyNext[0] = 1'b0;
        end
    end

    // Busy bitmap register; reset drops every pending producer
    always_ff @(posedge clk) begin
        if (rst) begin
            busyQ <= '0;
        end else begin
            busyQ <= busyNext;
        end
    end

    assign bus.SrcData1 = rdData1;
    assign bus.SrcData2 = rdData2;
    assign bus.Busy1    = rdBusy1;
    assign bus.Busy2    = rdBusy2;
    assign bus.BusyVec  = busyQ;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: a 16x16 instance exercised with directed and
// random traffic against a behavioural model, plus a 32x32 instance for a
// shuffled write/readback sweep. Expectations follow RF_BYPASS_EN.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    // Model state for the 16x16 instance and the 32x32 instance
    logic [15:0] regA [16];
    logic [15:0] busyA;
    logic [31:0] regB [32];

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(16), .NUM_REGS(16)) ifA ();
    regfile_sb_if #(.DATA_W(32), .NUM_REGS(32)) ifB ();

    regfile_sb #(.DATA_W(16), .NUM_REGS(16), .ZERO_REG(1)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA.slave)
    );

    regfile_sb #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(1)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB.slave)
    );

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word after a write in the given mode: whole word, low byte or high byte replaced
    function automatic logic [15:0] mergeA(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] mode);
        case (mode)
            2'd0:    return nw;
            2'd1:    return {old[15:8], nw[7:0]};
            2'd2:    return {nw[15:8], old[7:0]};
            default: return old;
        endcase
    endfunction

    // What a read port of instance A should show right now, before the coming edge
    function automatic logic [15:0] expRdA(input logic [3:0] idx);
        logic [15:0] v;
        v = regA[idx];
`ifdef RF_BYPASS_EN
        if (ifA.WriteReg && ifA.DstReg == idx && idx != 4'd0)
            v = mergeA(v, ifA.DstData, ifA.WMode);
`endif
        return v;
    endfunction

    function automatic logic expBusyA(input logic [3:0] idx);
        logic b;
        b = busyA[idx];
`ifdef RF_BYPASS_EN
        if (ifA.WriteReg && ifA.DstReg == idx) b = 1'b0;
`endif
        return b;
    endfunction

    // Drive all inputs of instance A
    task automatic applyStimulus(input logic wr, input logic [1:0] mode, input logic [3:0] dst,
                                 input logic [15:0] data, input logic iss, input logic [3:0] issReg,
                                 input logic [3:0] s1, input logic [3:0] s2);
        ifA.WriteReg = wr;
        ifA.WMode    = mode;
        ifA.DstReg   = dst;
        ifA.DstData  = data;
        ifA.IssueVld = iss;
        ifA.IssueReg = issReg;
        ifA.SrcReg1  = s1;
        ifA.SrcReg2  = s2;
    endtask

    task automatic idleA(input logic [3:0] s1, input logic [3:0] s2);
        applyStimulus(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 4'd0, s1, s2);
        #1;
    endtask

    // One clock edge: advance both models with the inputs present at the edge
    task automatic clockStep();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 16; r++) regA[r] = '0;
            for (int r = 0; r < 32; r++) regB[r] = '0;
            busyA = '0;
        end else begin
            if (ifA.WriteReg && ifA.DstReg != 4'd0)
                regA[ifA.DstReg] = mergeA(regA[ifA.DstReg], ifA.DstData, ifA.WMode);
            if (ifA.WriteReg) busyA[ifA.DstReg] = 1'b0;
            if (ifA.IssueVld && ifA.IssueReg != 4'd0) busyA[ifA.IssueReg] = 1'b1;
            if (ifB.WriteReg && ifB.DstReg != 5'd0 && ifB.WMode == 2'd0)
                regB[ifB.DstReg] = ifB.DstData;
        end
        #1;
    endtask

    int order [32];

    initial begin
        for (int r = 0; r < 16; r++) regA[r] = 16'hXXXX;
        for (int r = 0; r < 32; r++) regB[r] = 32'hXXXXXXXX;
        busyA = 16'hXXXX;
        ifB.WriteReg = 1'b0; ifB.WMode = 2'd0; ifB.DstReg = '0; ifB.DstData = '0;
        ifB.IssueVld = 1'b0; ifB.IssueReg = '0; ifB.SrcReg1 = '0; ifB.SrcReg2 = '0;

        // Reset with a write and an issue presented at the same edges
        rst = 1'b1;
        applyStimulus(1'b1, 2'd0, 4'd3, 16'hBEEF, 1'b1, 4'd4, 4'd3, 4'd3);
        clockStep();
        clockStep();
        rst = 1'b0;
        idleA(4'd3, 4'd3);
        checkOutput("rst_r3", ifA.SrcData1, 16'h0000);
        checkOutput("rst_busyvec", ifA.BusyVec, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            idleA(4'(i), 4'(15 - i));
            checkOutput($sformatf("rst_rd1_r%0d", i), ifA.SrcData1, 16'h0000);
            checkOutput($sformatf("rst_rd2_r%0d", 15 - i), ifA.SrcData2, 16'h0000);
        end

        // Full, low-half, high-half and reserved writes to r5
        applyStimulus(1'b1, 2'd0, 4'd5, 16'h1234, 1'b0, 4'd0, 4'd0, 4'd0);
        clockStep();
        idleA(4'd5, 4'd5);
        checkOutput("r5_full", ifA.SrcData1, 16'h1234);
        applyStimulus(1'b1, 2'd1, 4'd5, 16'hFFAB, 1'b0, 4'd0, 4'd0, 4'd0);
        clockStep();
        idleA(4'd5, 4'd5);
        checkOutput("r5_lo", ifA.SrcData1, 16'h12AB);
        applyStimulus(1'b1, 2'd2, 4'd5, 16'hCDFF, 1'b0, 4'd0, 4'd0, 4'd0);
        clockStep();
        idleA(4'd5, 4'd5);
        checkOutput("r5_hi", ifA.SrcData2, 16'hCDAB);
        applyStimulus(1'b1, 2'd3, 4'd5, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0);
        clockStep();
        idleA(4'd5, 4'd5);
        checkOutput("r5_rsvd", ifA.SrcData1, 16'hCDAB);

        // Zero register ignores writes and issues
        applyStimulus(1'b1, 2'd0, 4'd0, 16'h5555, 1'b0, 4'd0, 4'd0, 4'd0);
        clockStep();
        idleA(4'd0, 4'd0);
        checkOutput("r0_write", ifA.SrcData1, 16'h0000);
        applyStimulus(1'b0, 2'd0, 4'd0, 16'h0000, 1'b1, 4'd0, 4'd0, 4'd0);
        clockStep();
        idleA(4'd0, 4'd0);
        checkOutput("r0_issue", ifA.BusyVec[0], 1'b0);
        checkOutput("r0_busy1", ifA.Busy1, 1'b0);

        // Scoreboard: issue, clear, and issue-wins on collision
        applyStimulus(1'b0, 2'd0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd0, 4'd0);
        clockStep();
        idleA(4'd7, 4'd7);
        checkOutput("sb_issue_vec", ifA.BusyVec, 16'h0080);
        checkOutput("sb_issue_busy1", ifA.Busy1, 1'b1);
        applyStimulus(1'b1, 2'd3, 4'd7, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0);
        clockStep();
        idleA(4'd7, 4'd7);
        checkOutput("sb_clear_vec", ifA.BusyVec, 16'h0000);
        applyStimulus(1'b1, 2'd3, 4'd7, 16'h0000, 1'b1, 4'd7, 4'd0, 4'd0);
        clockStep();
        idleA(4'd7, 4'd7);
        checkOutput("sb_setwins", ifA.BusyVec[7], 1'b1);

        // Same-cycle write and read of a busy register
        applyStimulus(1'b1, 2'd0, 4'd9, 16'hAAAA, 1'b0, 4'd0, 4'd0, 4'd0);
        clockStep();
        applyStimulus(1'b0, 2'd0, 4'd0, 16'h0000, 1'b1, 4'd9, 4'd0, 4'd0);
        clockStep();
        applyStimulus(1'b1, 2'd1, 4'd9, 16'h0011, 1'b0, 4'd0, 4'd9, 4'd9);
        #1;
`ifdef RF_BYPASS_EN
        checkOutput("byp_rd1", ifA.SrcData1, 16'hAA11);
        checkOutput("byp_rd2", ifA.SrcData2, 16'hAA11);
        checkOutput("byp_busy1", ifA.Busy1, 1'b0);
`else
        checkOutput("byp_rd1", ifA.SrcData1, 16'hAAAA);
        checkOutput("byp_rd2", ifA.SrcData2, 16'hAAAA);
        checkOutput("byp_busy1", ifA.Busy1, 1'b1);
`endif
        clockStep();
        idleA(4'd9, 4'd9);
        checkOutput("byp_after", ifA.SrcData1, 16'hAA11);
        checkOutput("byp_after_busy", ifA.BusyVec[9], 1'b0);

        // Random traffic including occasional mid-hazard reset
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                          16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) ifA.SrcReg2 = ifA.SrcReg1;
            if ($urandom_range(0, 3) == 0) ifA.SrcReg1 = ifA.DstReg;
            #1;
            checkOutput("rnd_rd1", ifA.SrcData1, expRdA(ifA.SrcReg1));
            checkOutput("rnd_rd2", ifA.SrcData2, expRdA(ifA.SrcReg2));
            checkOutput("rnd_busy1", ifA.Busy1, expBusyA(ifA.SrcReg1));
            checkOutput("rnd_busy2", ifA.Busy2, expBusyA(ifA.SrcReg2));
            clockStep();
            checkOutput("rnd_busyvec", ifA.BusyVec, busyA);
        end
        rst = 1'b0;
        idleA(4'd0, 4'd0);

        // Shuffled write sweep on the 32x32 instance, then readback on both ports
        for (int i = 0; i < 32; i++) order[i] = i;
        for (int i = 31; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(0, i);
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int k = 0; k < 32; k++) begin
            ifB.WriteReg = 1'b1;
            ifB.WMode    = 2'd0;
            ifB.DstReg   = 5'(order[k]);
            ifB.DstData  = 32'(order[k]) * 32'h01010101;
            clockStep();
        end
        ifB.WriteReg = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ifB.SrcReg1 = 5'(i);
            ifB.SrcReg2 = 5'(i);
            #1;
            checkOutput($sformatf("sweep_rd1_r%0d", i), ifB.SrcData1, 32'(i) * 32'h01010101);
            checkOutput($sformatf("sweep_rd2_r%0d", i), ifB.SrcData2, regB[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 16x16 CPU register file.
- Provides N registers of DATA_W bits, two combinational read ports and one write port.
- The write port supports full, low-half and high-half writes, generalising the LLB/LHB writes.
- Adds a per-register busy scoreboard that the decode stage uses for RAW hazard detection in the pipelined core. The block sits between decode (read/issue) and writeback (write/clear).

Parameters:
- DATA_W, 16, register width in bits; must be even and at least 2.
- NUM_REGS, 16, number of registers; must be a power of 2 and at least 2.
- ADDR_W, $clog2(NUM_REGS), register index width; derived, do not override.
- ZERO_REG, 1, if 1 then register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- SrcReg1  in  ADDR_W  read port 1 index.
- SrcReg2  in  ADDR_W  read port 2 index.
- SrcData1  out  DATA_W  read port 1 data (combinational).
- SrcData2  out  DATA_W  read port 2 data (combinational).
- DstReg  in  ADDR_W  write index.
- WriteReg  in  1  write enable; also clears the busy bit of DstReg.
- WMode  in  2  write mode: 00 full, 01 low half, 10 high half, 11 reserved.
- DstData  in  DATA_W  write data.
- IssueVld  in  1  a producer instruction issued this cycle.
- IssueReg  in  ADDR_W  destination of the issued producer.
- Busy1  out  1  busy bit of SrcReg1 (combinational).
- Busy2  out  1  busy bit of SrcReg2 (combinational).
- BusyVec  out  NUM_REGS  registered busy bitmap.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all registers go to 0; BusyVec goes to 0.
  - reset overrides any write or issue presented in the same cycle.
  - reset mid-hazard drops all pending busy bits.
- Reads:
  - SrcDataN = reg[SrcRegN], purely combinational.
  - SrcReg1 == SrcReg2 is legal; both ports return the same value.
  - if ZERO_REG=1 and the index is 0, the port returns 0.
- Write:
  - on a clk edge with WriteReg=1 and rst=0, the lanes of reg[DstReg] selected by WMode update; all other bits hold.
  - WMode=00 writes all bits. 01 writes bits [DATA_W/2-1:0] from DstData[DATA_W/2-1:0]. 10 writes bits [DATA_W-1:DATA_W/2] from DstData[DATA_W-1:DATA_W/2].
  - WMode=11 writes nothing; the busy bit is still cleared.
  - writes to index 0 with ZERO_REG=1 are dropped.
  - without bypass, written data is visible on the read ports the cycle after the edge (1-cycle latency).
- Scoreboard, applied on each clk edge with rst=0:
  - WriteReg=1 clears busy[DstReg].
  - IssueVld=1 sets busy[IssueReg].
  - if both hit the same index in one cycle, set wins: the new producer is still pending.
  - issuing to an already-busy register keeps it busy; there is no counting and the latest producer owns the bit.
  - IssueReg=0 with ZERO_REG=1 is ignored.
  - BusyN = BusyVec[SrcRegN], except it is forced to 0 when a same-cycle write with WriteReg=1 and DstReg==SrcRegN clears that bit (write-clear lookahead). The lookahead applies only under RF_BYPASS_EN; otherwise BusyN = BusyVec[SrcRegN].
- WMode, IssueReg and DstReg are sampled only when their qualifying enable is high.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - write-through forwarding: when WriteReg=1 and DstReg==SrcRegN (not the zero register), SrcDataN returns the merged value.
  - the merged value is the new lanes selected by WMode plus the old register bits for the lanes not written.
  - Busy lookahead is enabled as described above.
  - read-after-write latency becomes 0 cycles.
- Undefined:
  - reads return the pre-edge register contents.
  - BusyN reflects the registered bitmap only.

Decomposition:
- Package rf_pkg holds:
  - the wmode_t 2-bit enum: WM_FULL, WM_LO, WM_HI, WM_RSVD.
  - a function that returns the DATA_W half-lane write mask for a given WMode.
  - the default DATA_W and NUM_REGS constants.
- Sub-module rf_word: one DATA_W register with clk, rst, a write enable and a per-bit write mask. Instantiate it NUM_REGS times (or NUM_REGS-1 when ZERO_REG=1).
- The scoreboard stays inline; it is about 20 lines.

Test Plan:
- Reset, then read all indices -> every SrcData is 0 and BusyVec=0. Write 0xBEEF to r3 with rst=1 in the same cycle -> r3 still 0.
- Full write 0x1234 to r5 (WMode=00) -> r5 reads 0x1234 next cycle. Then WMode=01 with 0xFFAB -> r5=0x12AB. Then WMode=10 with 0xCDFF -> r5=0xCDAB. Then WMode=11 with 0x0000 -> r5 unchanged at 0xCDAB.
- ZERO_REG=1:
  - write 0x5555 to r0 -> r0 reads 0.
  - IssueVld with IssueReg=0 -> BusyVec[0] stays 0.
- Scoreboard:
  - issue r7 -> BusyVec=0x0080 next cycle; Busy1=1 with SrcReg1=7.
  - write r7 -> bit clears.
  - issue r7 and write r7 in the same cycle -> BusyVec[7] stays 1.
- RF_BYPASS_EN defined, r9=0xAAAA:
  - WriteReg with WMode=01, DstData=0x0011, DstReg=SrcReg1=SrcReg2=9 -> both ports return 0xAA11 in the same cycle.
  - Busy1=0 for that read, assuming r9 was busy before the write.
  - with the macro undefined, the same stimulus returns 0xAAAA.
- Randomised-order sweep (NUM_REGS=32, DATA_W=32 instance): write index i with value i*0x01010101 -> readback on both ports matches for all 32 indices.
